// File: rtl/axi_lite_req_arbiter.sv
// 2:1 arbiter sharing one AXI4-Lite master request port between IF (port 0) and MEM (port 1).
// Define ARB_ROUND_ROBIN_EN for round-robin tie-break; otherwise MEM has fixed priority.
module axi_lite_req_arbiter #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                if_req_i,
  input  logic [ADDR_W-1:0]   if_addr_i,
  output logic [DATA_W-1:0]   if_rdata_o,
  output logic                if_ready_o,
  output logic                if_error_o,
  input  logic                mem_req_i,
  input  logic                mem_wr_i,
  input  logic [ADDR_W-1:0]   mem_addr_i,
  input  logic [DATA_W-1:0]   mem_wdata_i,
  input  logic [DATA_W/8-1:0] mem_wstrb_i,
  output logic [DATA_W-1:0]   mem_rdata_o,
  output logic                mem_ready_o,
  output logic                mem_error_o,
  output logic                m_req_o,
  output logic                m_wr_o,
  output logic [ADDR_W-1:0]   m_addr_o,
  output logic [DATA_W-1:0]   m_wdata_o,
  output logic [DATA_W/8-1:0] m_wstrb_o,
  input  logic [DATA_W-1:0]   m_rdata_i,
  input  logic                m_ready_i,
  input  logic                m_error_i,
  output logic [1:0]          gnt_o,
  output logic                busy_o
);

  localparam int unsigned StrbW = DATA_W / 8;

  typedef enum logic [1:0] {StIdle, StIssue, StWait, StResp} state_e;

  state_e              state_q;
  logic [1:0]          gnt_q;
  logic                last_gnt_q;  // 0 = IF, 1 = MEM
  logic                m_req_q;
  logic                m_wr_q;
  logic [ADDR_W-1:0]   m_addr_q;
  logic [DATA_W-1:0]   m_wdata_q;
  logic [StrbW-1:0]    m_wstrb_q;
  logic [DATA_W-1:0]   if_rdata_q;
  logic                if_ready_q;
  logic                if_error_q;
  logic [DATA_W-1:0]   mem_rdata_q;
  logic                mem_ready_q;
  logic                mem_error_q;
  logic                pick_mem;

`ifdef ARB_ROUND_ROBIN_EN
  // On a tie, serve the port that was not granted last.
  assign pick_mem = mem_req_i & (~if_req_i | ~last_gnt_q);
`else
  logic unused_last_gnt;
  assign unused_last_gnt = last_gnt_q;
  assign pick_mem        = mem_req_i;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      gnt_q       <= 2'b00;
      last_gnt_q  <= 1'b0;
      m_req_q     <= 1'b0;
      m_wr_q      <= 1'b0;
      m_addr_q    <= '0;
      m_wdata_q   <= '0;
      m_wstrb_q   <= '0;
      if_rdata_q  <= '0;
      if_ready_q  <= 1'b0;
      if_error_q  <= 1'b0;
      mem_rdata_q <= '0;
      mem_ready_q <= 1'b0;
      mem_error_q <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (if_req_i || mem_req_i) begin
            state_q <= StIssue;
            m_req_q <= 1'b1;
            if (pick_mem) begin
              gnt_q     <= 2'b10;
              m_wr_q    <= mem_wr_i;
              m_addr_q  <= mem_addr_i;
              m_wdata_q <= mem_wdata_i;
              m_wstrb_q <= mem_wstrb_i;
            end else begin
              gnt_q     <= 2'b01;
              m_wr_q    <= 1'b0;
              m_addr_q  <= if_addr_i;
              m_wdata_q <= '0;
              m_wstrb_q <= '0;
            end
          end
        end
        StIssue: begin
          m_req_q <= 1'b0;
          state_q <= StWait;
        end
        StWait: begin
          if (m_ready_i) begin
            state_q <= StResp;
            if (gnt_q[1]) begin
              mem_rdata_q <= m_rdata_i;
              mem_error_q <= m_error_i;
              mem_ready_q <= 1'b1;
            end else begin
              if_rdata_q <= m_rdata_i;
              if_error_q <= m_error_i;
              if_ready_q <= 1'b1;
            end
          end
        end
        StResp: begin
          if_ready_q  <= 1'b0;
          mem_ready_q <= 1'b0;
          last_gnt_q  <= gnt_q[1];
          gnt_q       <= 2'b00;
          state_q     <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign m_req_o     = m_req_q;
  assign m_wr_o      = m_wr_q;
  assign m_addr_o    = m_addr_q;
  assign m_wdata_o   = m_wdata_q;
  assign m_wstrb_o   = m_wstrb_q;
  assign if_rdata_o  = if_rdata_q;
  assign if_ready_o  = if_ready_q;
  assign if_error_o  = if_error_q;
  assign mem_rdata_o = mem_rdata_q;
  assign mem_ready_o = mem_ready_q;
  assign mem_error_o = mem_error_q;
  assign gnt_o       = gnt_q;
  assign busy_o      = (state_q != StIdle);

endmodule
